// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder: one result per accepted cycle, 1-cycle latency.
// Optional op/carry statistics counters are compiled in with HALF_ADDER_STATS_EN.
module half_adder_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  logic sum_q, sum_d, carry_q, carry_d;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (en_i) begin
      sum_d   = a_i ^ b_i;
      carry_d = a_i & b_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
endmodule

module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [15:0]      op_count,
  output logic [15:0]      carry_count
`endif
);
  // Assert asynchronously, release two edges after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  logic any_cy;
  logic vld_q, vld_d, any_q, any_d;

  assign any_cy = |(a & b);

  always_comb begin
    vld_d = in_valid;
    any_d = any_q;
    if (in_valid) any_d = any_cy;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      vld_q <= 1'b0;
      any_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      any_q <= any_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_sync_n),
      .en_i    (in_valid),
      .a_i     (a[i]),
      .b_i     (b[i]),
      .sum_o   (sum[i]),
      .carry_o (carry[i])
    );
  end

  assign out_valid = vld_q;
  assign carry_any = any_q;

`ifdef HALF_ADDER_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d, cy_cnt_q, cy_cnt_d;

  // Saturating: once at all-ones the counters stay there.
  always_comb begin
    op_cnt_d = op_cnt_q;
    cy_cnt_d = cy_cnt_q;
    if (in_valid) begin
      if (op_cnt_q != 16'hFFFF)           op_cnt_d = op_cnt_q + 16'd1;
      if (any_cy && cy_cnt_q != 16'hFFFF) cy_cnt_d = cy_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      op_cnt_q <= 16'd0;
      cy_cnt_q <= 16'd0;
    end else begin
      op_cnt_q <= op_cnt_d;
      cy_cnt_q <= cy_cnt_d;
    end
  end

  assign op_count    = op_cnt_q;
  assign carry_count = cy_cnt_q;
`endif
endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: vector table, random stream vs arithmetic model, reset and stats corners.
module tb_half_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ov4, any4, ov1, any1;
  logic [3:0] s4, c4;
  logic [0:0] s1, c1;
`ifdef HALF_ADDER_STATS_EN
  logic [15:0] opc4, cyc4, opc1, cyc1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(ov4), .sum(s4), .carry(c4), .carry_any(any4)
`ifdef HALF_ADDER_STATS_EN
    , .op_count(opc4), .carry_count(cyc4)
`endif
  );

  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4[0:0]), .b(b4[0:0]),
    .out_valid(ov1), .sum(s1), .carry(c1), .carry_any(any1)
`ifdef HALF_ADDER_STATS_EN
    , .op_count(opc1), .carry_count(cyc1)
`endif
  );

  // Reference: each lane is a 1-bit addition, sum = total mod 2, carry = total div 2.
  logic       m_vld = 1'b0;
  logic [3:0] m_sum = '0, m_cy = '0;

  task automatic model_edge();
    if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        int t;
        t = int'(a4[i]) + int'(b4[i]);
        m_sum[i] = (t % 2) == 1;
        m_cy[i]  = (t / 2) == 1;
      end
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ov4"},  64'(ov4),  64'(m_vld));
    chk({tag, " s4"},   64'(s4),   64'(m_sum));
    chk({tag, " c4"},   64'(c4),   64'(m_cy));
    chk({tag, " any4"}, 64'(any4), 64'(m_cy != 4'd0));
    chk({tag, " ov1"},  64'(ov1),  64'(m_vld));
    chk({tag, " s1"},   64'(s1),   64'(m_sum[0]));
    chk({tag, " c1"},   64'(c1),   64'(m_cy[0]));
    chk({tag, " any1"}, 64'(any1), 64'(m_cy[0]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ov4"}, 64'(ov4), 64'd0);
    chk({tag, " s4"},  64'(s4),  64'd0);
    chk({tag, " c4"},  64'(c4),  64'd0);
    chk({tag, " any4"},64'(any4),64'd0);
    chk({tag, " ov1"}, 64'(ov1), 64'd0);
    chk({tag, " s1c1"},64'({s1, c1}), 64'd0);
`ifdef HALF_ADDER_STATS_EN
    chk({tag, " opc4"},64'(opc4),64'd0);
    chk({tag, " cyc4"},64'(cyc4),64'd0);
`endif
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_vld = 1'b0; m_sum = '0; m_cy = '0;
    in_valid = 1'b0;
    check_zero("reset_async");
    step();
    #1 rst_n = 1'b1;
    // Let the internal synchronizer release; inputs are noise with in_valid low.
    for (int i = 0; i < 4; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom);
      step();
      check_zero("post_release");
    end
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic       vld;
    logic [3:0] es, ec;
    logic       eany, evld;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[1] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1};
    tbl[2] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1};
    tbl[3] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1};
    tbl[4] = '{4'b1100, 4'b1010, 1'b1, 4'b0110, 4'b1000, 1'b1, 1'b1};
    tbl[5] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1};
    tbl[6] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[7] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[8] = '{4'b1111, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1};
    tbl[9] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1};

    do_reset();

    foreach (tbl[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      a4 = tbl[k].a; b4 = tbl[k].b; in_valid = tbl[k].vld;
      step();
      chk({tag, " ov4"},  64'(ov4),  64'(tbl[k].evld));
      chk({tag, " s4"},   64'(s4),   64'(tbl[k].es));
      chk({tag, " c4"},   64'(c4),   64'(tbl[k].ec));
      chk({tag, " any4"}, 64'(any4), 64'(tbl[k].eany));
      chk({tag, " ov1"},  64'(ov1),  64'(tbl[k].evld));
      chk({tag, " s1"},   64'(s1),   64'(tbl[k].es[0]));
      chk({tag, " c1"},   64'(c1),   64'(tbl[k].ec[0]));
    end

    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      step();
      check_model("rand");
      chk("rand sum_and_carry", 64'(s4 & c4), 64'd0);
    end

    // Reset lands between edges while a result is showing and another is queued.
    in_valid = 1'b1; a4 = 4'b1111; b4 = 4'b0101;
    step();
    check_model("pre_reset");
    a4 = 4'b0011; b4 = 4'b0011;
    do_reset();
    step();
    check_model("after_reset");

`ifdef HALF_ADDER_STATS_EN
    for (int p = 0; p < 4; p++) begin
      in_valid = 1'b1; a4 = {3'b000, p[1]}; b4 = {3'b000, p[0]};
      step();
      check_model("stats_seq");
    end
    in_valid = 1'b0; a4 = 4'b1111; b4 = 4'b1111;
    step();
    chk("op_count4", 64'(opc1), 64'd4);
    chk("carry_count1", 64'(cyc1), 64'd1);
    in_valid = 1'b1; a4 = 4'b0001; b4 = 4'b0001;
    for (int n = 0; n < 70000; n++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("op_count_sat", 64'(opc1), 64'hFFFF);
    chk("carry_count_sat", 64'(cyc1), 64'hFFFF);
    chk("op_count_sat4", 64'(opc4), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
